multi_pulse_gen: RTL and testbench

- N-channel single-pulse generator. Each channel synchronises, debounces and edge-detects a multi-cycle input level, then emits a one-clock pulse.
- Per-channel mode selects rising-edge, falling-edge, both-edge or rising-edge with auto-repeat (keyboard-style typematic).
- Sits between push-button or slow control inputs and the synchronous logic that consumes single-cycle strobes.

---
 rtl/multi_pulse_pkg.sv | 17 +
 rtl/pulse_chan.sv | 119 +++++++++++
 rtl/multi_pulse_gen.sv | 39 +++
 tb/tb_multi_pulse_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_pulse_pkg.sv
// rtl/multi_pulse_pkg.sv - shared mode codes and repeat FSM state encoding
package multi_pulse_pkg;

    // Per-channel mode field values
    localparam logic [1:0] MODE_RISE   = 2'd0;
    localparam logic [1:0] MODE_FALL   = 2'd1;
    localparam logic [1:0] MODE_BOTH   = 2'd2;
    localparam logic [1:0] MODE_REPEAT = 2'd3;

    // Auto-repeat state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/pulse_chan.sv
// rtl/pulse_chan.sv - one channel: synchroniser, debounce, edge detect, auto-repeat
//
// Ports:
//   clk     system clock, rising edge
//   rst_l   asynchronous active-low reset
//   ub      raw (possibly asynchronous) input level
//   mode    0 rise, 1 fall, 2 both, 3 rise with auto-repeat
//   ubsing  registered one-cycle pulse
//   ublvl   registered debounced level
module pulse_chan
    import multi_pulse_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       ub,
    input  logic [1:0] mode,
    output logic       ubsing,
    output logic       ublvl
);

    localparam int DW    = $clog2(DB_CYCLES + 1);
    localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW    = $clog2(RMAX);

    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LOAD  = RW'(REPEAT_PERIOD - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] db_cnt;
    logic          lvl_nxt;
    logic          rise_ev;
    logic          fall_ev;
    rpt_state_t    state;
    logic [RW-1:0] rpt_cnt;
    logic          pulse_q;

    // Synchroniser and debounce
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            ublvl  <= 1'b0;
        end else begin
            sync1 <= ub;
            sync2 <= sync1;
            if (sync2 == ublvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                ublvl  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Edges are judged on the value ublvl is about to take, so the mode
    // sampled alongside belongs to the same cycle as the level change.
    assign lvl_nxt = ((sync2 != ublvl) && (db_cnt == DB_LAST)) ? sync2 : ublvl;
    assign rise_ev = lvl_nxt & ~ublvl;
    assign fall_ev = ~lvl_nxt & ublvl;

    // Pulse decision and repeat FSM; pulse_q is re-registered into ubsing
    // so the strobe lands one edge after the debounced level changes.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
            pulse_q <= 1'b0;
            ubsing  <= 1'b0;
        end else begin
            ubsing  <= pulse_q;
            pulse_q <= 1'b0;
            if (mode != MODE_REPEAT) begin
                state   <= ST_IDLE;
                rpt_cnt <= '0;
                case (mode)
                    MODE_RISE: pulse_q <= rise_ev;
                    MODE_FALL: pulse_q <= fall_ev;
                    default:   pulse_q <= rise_ev | fall_ev;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise_ev) begin
                            pulse_q <= 1'b1;
                            rpt_cnt <= RD_LOAD;
                            state   <= ST_HOLD;
                        end
                    end
                    ST_HOLD, ST_REPEAT: begin
                        if (fall_ev) begin
                            state   <= ST_IDLE;
                            rpt_cnt <= '0;
                        end else if (rpt_cnt == '0) begin
                            pulse_q <= 1'b1;
                            rpt_cnt <= RP_LOAD;
                            state   <= ST_REPEAT;
                        end else begin
                            rpt_cnt <= rpt_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_pulse_gen.sv
// rtl/multi_pulse_gen.sv - N independent debounced single-pulse generators
//
// Ports:
//   clk     system clock, rising edge
//   rst_l   asynchronous active-low reset
//   ub      N raw input levels
//   mode    2 bits per channel, bits [2i+1:2i] for channel i
//   ubsing  N registered one-cycle pulses
//   ublvl   N registered debounced levels
module multi_pulse_gen #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic [N-1:0]   ub,
    input  logic [2*N-1:0] mode,
    output logic [N-1:0]   ubsing,
    output logic [N-1:0]   ublvl
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        pulse_chan #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk    (clk),
            .rst_l  (rst_l),
            .ub     (ub[i]),
            .mode   (mode[2*i +: 2]),
            .ubsing (ubsing[i]),
            .ublvl  (ublvl[i])
        );
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb/tb_multi_pulse_gen.sv - directed scoreboard bench for multi_pulse_gen
module tb_multi_pulse_gen;

    logic       clk;
    logic       rst_l;
    logic [3:0] ub;
    logic [7:0] mode;
    logic [3:0] ubsing;
    logic [3:0] ublvl;

    typedef struct {
        int ch;
        int at;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   vecs;
    int   errs;
    int   c;

    multi_pulse_gen #(
        .N             (4),
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .clk    (clk),
        .rst_l  (rst_l),
        .ub     (ub),
        .mode   (mode),
        .ubsing (ubsing),
        .ublvl  (ublvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_pulse(input int ch, input int at);
        exp_t e;
        e.ch = ch;
        e.at = at;
        sb.push_back(e);
    endtask

    // Pop and compare every observed pulse against the scoreboard.
    task automatic monitor();
        for (int i = 0; i < 4; i++) begin
            if (ubsing[i] === 1'b1) begin
                int idx;
                idx = -1;
                foreach (sb[j]) if (idx < 0 && sb[j].ch == i) idx = j;
                vecs++;
                assert (idx >= 0) else begin
                    errs++;
                    $error("FAIL unexpected_pulse ch%0d: pulse at cycle %0d, none expected", i, cyc);
                end
                if (idx >= 0) begin
                    vecs++;
                    assert (cyc === sb[idx].at) else begin
                        errs++;
                        $error("FAIL pulse_time ch%0d: got cycle %0d, expected %0d", i, cyc, sb[idx].at);
                    end
                    sb.delete(idx);
                end
            end
        end
    endtask

    // Advance n clock edges; outputs are sampled on each falling edge and
    // the call returns on a falling edge, where inputs are then driven.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc   = 0;
        vecs  = 0;
        errs  = 0;
        rst_l = 1'b0;
        ub    = 4'hF;
        mode  = 8'h00;

        // Reset with all inputs high
        step(3);
        chk("reset_ubsing", ubsing, 4'h0);
        chk("reset_ublvl", ublvl, 4'h0);
        c = cyc;
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) expect_pulse(i, c + 7);
        step(5);
        chk("lvl_before_accept", ublvl, 4'h0);
        step(1);
        chk("lvl_after_accept", ublvl, 4'hF);
        ub = 4'h0;
        step(15);
        chk("lvl_all_low", ublvl, 4'h0);

        // Debounce: 3-cycle glitch rejected, long level accepted
        ub[0] = 1'b1;
        step(3);
        ub[0] = 1'b0;
        step(10);
        chk("glitch_lvl0", {3'b0, ublvl[0]}, 4'h0);
        c = cyc;
        ub[0] = 1'b1;
        expect_pulse(0, c + 7);
        step(5);
        chk("db_lvl0_early", {3'b0, ublvl[0]}, 4'h0);
        step(1);
        chk("db_lvl0_rise", {3'b0, ublvl[0]}, 4'h1);
        step(4);
        ub[0] = 1'b0;
        step(15);
        chk("db_lvl0_fall", ublvl, 4'h0);

        // Edge modes: ch1 falling, ch2 both
        mode = 8'b00_10_01_00;
        step(2);
        c = cyc;
        ub[2:1] = 2'b11;
        expect_pulse(2, c + 7);
        step(12);
        chk("edge_lvl_high", ublvl, 4'b0110);
        ub[2:1] = 2'b00;
        expect_pulse(1, c + 19);
        expect_pulse(2, c + 19);
        step(25);
        chk("edge_lvl_low", ublvl, 4'h0);

        // Auto-repeat on ch3
        mode = 8'b11_00_00_00;
        step(2);
        c = cyc;
        ub[3] = 1'b1;
        expect_pulse(3, c + 7);
        expect_pulse(3, c + 27);
        expect_pulse(3, c + 35);
        expect_pulse(3, c + 43);
        expect_pulse(3, c + 51);
        expect_pulse(3, c + 59);
        step(60);
        ub[3] = 1'b0;
        step(20);
        chk("repeat_lvl_low", ublvl, 4'h0);

        // Mode change mid-hold: 3 -> 0 stops repeats, 0 -> 3 waits for a rise
        c = cyc;
        ub[3] = 1'b1;
        expect_pulse(3, c + 7);
        expect_pulse(3, c + 27);
        step(31);
        mode[7:6] = 2'd0;
        step(10);
        mode[7:6] = 2'd3;
        step(20);
        chk("modechg_lvl_held", ublvl, 4'h8);
        ub[3] = 1'b0;
        step(15);

        // Reset in the middle of a repeat sequence
        c = cyc;
        ub[3] = 1'b1;
        expect_pulse(3, c + 7);
        expect_pulse(3, c + 27);
        step(32);
        chk("pre_reset_lvl", ublvl, 4'h8);
        rst_l = 1'b0;
        #1;
        chk("async_reset_lvl", ublvl, 4'h0);
        chk("async_reset_sing", ubsing, 4'h0);
        step(3);
        c = cyc;
        rst_l = 1'b1;
        expect_pulse(3, c + 7);
        expect_pulse(3, c + 27);
        step(25);
        ub[3] = 1'b0;
        step(20);
        chk("post_reset_lvl_low", ublvl, 4'h0);

        vecs++;
        assert (sb.size() === 0) else begin
            errs++;
            $error("FAIL missing_pulses: %0d expected pulses never seen, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
